// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared register-index constants and default widths
package mips_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  typedef logic [DEF_ADDR_W-1:0] reg_idx_t;

  // Register indices. The destination mux select encoding reuses these.
  localparam reg_idx_t REG_ZERO = 5'd0;
  localparam reg_idx_t REG_RA   = 5'd31;

endpackage

// File: rtl/regfile_rd_port.sv
// rtl/regfile_rd_port.sv - one combinational register read port with write bypass
module regfile_rd_port
  import mips_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic [ADDR_W-1:0]                  i_raddr,
  input  logic                               i_byp_en,
  input  logic [ADDR_W-1:0]                  i_waddr,
  input  logic [DATA_W-1:0]                  i_wdata,
  input  logic [(2**ADDR_W)-1:0][DATA_W-1:0] i_regs,
  output logic [DATA_W-1:0]                  o_rdata
);

  // Priority: $0 reads zero, then same-cycle write data, then the stored value.
  always_comb begin
    o_rdata = i_regs[i_raddr];
    if (i_raddr == ADDR_W'(REG_ZERO)) begin
      o_rdata = '0;
    end else if (i_byp_en && (i_waddr == i_raddr)) begin
      o_rdata = i_wdata;
    end
  end

endmodule

// File: rtl/regfile_wb.sv
// rtl/regfile_wb.sv - 32x32 register file with write-back commit tracking
module regfile_wb
  import mips_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic              wb_valid,
  output logic [ADDR_W-1:0] wb_addr
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0] r_regs;
  logic                         r_wb_valid;
  logic [ADDR_W-1:0]            r_wb_addr;
  logic                         w_wr_en;
  logic                         w_byp_en;

  // An unknown waddr makes this X, which the storage block treats as "no write".
  assign w_wr_en  = we && (waddr != ADDR_W'(REG_ZERO));
  // Reset suppresses the bypass so every read is zero while rst_n is low.
  assign w_byp_en = we && rst_n;

  // Storage: commit write-back data; slot 0 never takes a write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_regs <= '0;
    end else if (w_wr_en) begin
      r_regs[waddr] <= wdata;
    end
  end

  // Commit tracking: one-cycle pulse per accepted write, index held between writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_valid <= 1'b0;
      r_wb_addr  <= '0;
    end else begin
      r_wb_valid <= w_wr_en;
      if (w_wr_en) begin
        r_wb_addr <= waddr;
      end
    end
  end

  a_waddr_known: assert property (@(posedge clk) disable iff (!rst_n) we |-> !$isunknown(waddr));

  regfile_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd_port1 (
    .i_raddr  (raddr1),
    .i_byp_en (w_byp_en),
    .i_waddr  (waddr),
    .i_wdata  (wdata),
    .i_regs   (r_regs),
    .o_rdata  (rdata1)
  );

  regfile_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd_port2 (
    .i_raddr  (raddr2),
    .i_byp_en (w_byp_en),
    .i_waddr  (waddr),
    .i_wdata  (wdata),
    .i_regs   (r_regs),
    .o_rdata  (rdata2)
  );

  assign wb_valid = r_wb_valid;
  assign wb_addr  = r_wb_addr;

endmodule

// File: tb/tb_regfile_wb.sv
// tb/tb_regfile_wb.sv - self-checking bench for regfile_wb
module tb_regfile_wb;
  import mips_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk    = 1'b0;
  logic          rst_n  = 1'b1;
  logic          we     = 1'b0;
  reg_idx_t      waddr  = '0;
  logic [DW-1:0] wdata  = '0;
  reg_idx_t      raddr1 = '0;
  reg_idx_t      raddr2 = '0;
  logic [DW-1:0] rdata1;
  logic [DW-1:0] rdata2;
  logic          wb_valid;
  reg_idx_t      wb_addr;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  regfile_wb #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .raddr1   (raddr1),
    .raddr2   (raddr2),
    .rdata1   (rdata1),
    .rdata2   (rdata2),
    .wb_valid (wb_valid),
    .wb_addr  (wb_addr)
  );

  always #5 clk = ~clk;

  // Reference model: plain array of register contents plus last-commit info.
  logic [DW-1:0] m_regs [32];
  logic          m_valid = 1'b0;
  reg_idx_t      m_addr  = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      foreach (m_regs[i]) m_regs[i] = '0;
      m_valid = 1'b0;
      m_addr  = '0;
    end else begin
      m_valid = we && (waddr != 0);
      if (m_valid) begin
        m_regs[waddr] = wdata;
        m_addr = waddr;
      end
    end
  end

  function automatic logic [DW-1:0] exp_rd(input reg_idx_t ra);
    if (!rst_n || ra == 0) return '0;
    if (we && waddr == ra) return wdata;
    return m_regs[ra];
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: DUT vs model on every falling edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_rdata1", rdata1, exp_rd(raddr1));
      check("model_rdata2", rdata2, exp_rd(raddr2));
      check("model_wb_valid", {31'd0, wb_valid}, {31'd0, m_valid});
      check("model_wb_addr", {27'd0, wb_addr}, {27'd0, m_addr});
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic w, input reg_idx_t a, input logic [DW-1:0] d,
                       input reg_idx_t r1, input reg_idx_t r2);
    we = w; waddr = a; wdata = d; raddr1 = r1; raddr2 = r2;
  endtask

  initial begin
    foreach (m_regs[i]) m_regs[i] = '0;
    #1 rst_n = 1'b0;
    #11;
    check("reset_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("reset_wb_addr", {27'd0, wb_addr}, 32'd0);
    rst_n = 1'b1;
    cmp_en = 1'b1;
    step();

    // Basic write/read
    drive(1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0);
    step();
    drive(1'b0, 5'd0, 32'd0, 5'd5, 5'd0);
    #1;
    check("basic_rdata1", rdata1, 32'hDEADBEEF);
    check("basic_wb_valid", {31'd0, wb_valid}, 32'd1);
    check("basic_wb_addr", {27'd0, wb_addr}, 32'd5);
    step();
    check("basic_wb_pulse_end", {31'd0, wb_valid}, 32'd0);
    check("basic_wb_addr_hold", {27'd0, wb_addr}, 32'd5);

    // $0 protection
    drive(1'b1, REG_ZERO, 32'hFFFFFFFF, REG_ZERO, 5'd5);
    #1;
    check("zero_bypass_rdata1", rdata1, 32'd0);
    step();
    drive(1'b0, 5'd0, 32'd0, REG_ZERO, 5'd5);
    #1;
    check("zero_rdata1", rdata1, 32'd0);
    check("zero_other_reg", rdata2, 32'hDEADBEEF);
    check("zero_wb_valid", {31'd0, wb_valid}, 32'd0);

    // Bypass on $31
    drive(1'b1, REG_RA, 32'h1, 5'd0, 5'd0);
    step();
    drive(1'b1, REG_RA, 32'h00400008, REG_RA, REG_RA);
    #1;
    check("bypass_rdata1", rdata1, 32'h00400008);
    check("bypass_rdata2", rdata2, 32'h00400008);
    step();
    drive(1'b0, 5'd0, 32'd0, REG_RA, REG_RA);
    #1;
    check("post_bypass_rdata1", rdata1, 32'h00400008);
    check("post_bypass_rdata2", rdata2, 32'h00400008);

    // Back-to-back writes
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, reg_idx_t'(i), 32'(i * 10), 5'd0, 5'd0);
      step();
      check("b2b_wb_valid", {31'd0, wb_valid}, 32'd1);
      check("b2b_wb_addr", {27'd0, wb_addr}, 32'(i));
    end
    drive(1'b0, 5'd0, 32'd0, 5'd1, 5'd2);
    #1;
    check("b2b_read1", rdata1, 32'd10);
    check("b2b_read2", rdata2, 32'd20);
    raddr1 = 5'd3;
    #1;
    check("b2b_read3", rdata1, 32'd30);
    step();

    // A few more writes covered by the model
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, reg_idx_t'($urandom_range(0, 31)), $urandom,
            reg_idx_t'($urandom_range(0, 31)), reg_idx_t'($urandom_range(0, 31)));
      step();
    end
    drive(1'b0, 5'd0, 32'd0, 5'd5, 5'd31);

    // Asynchronous reset between edges with preloaded registers
    #1 rst_n = 1'b0;
    #1;
    check("async_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("async_wb_addr", {27'd0, wb_addr}, 32'd0);
    for (int i = 0; i < 32; i++) begin
      raddr1 = reg_idx_t'(i);
      raddr2 = reg_idx_t'(31 - i);
      #1;
      check("async_rdata1", rdata1, 32'd0);
      check("async_rdata2", rdata2, 32'd0);
    end
    drive(1'b1, 5'd4, 32'hABCD, 5'd4, 5'd4);
    #1;
    check("reset_no_bypass", rdata1, 32'd0);
    step();
    drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    rst_n = 1'b1;
    step();

    // Reset asserted in the same cycle as a write to $7
    drive(1'b1, 5'd7, 32'h55, 5'd7, 5'd7);
    rst_n = 1'b0;
    step();
    wdata = 32'h77;
    #1;
    check("midreset_rdata", rdata1, 32'd0);
    rst_n = 1'b1;
    raddr2 = 5'd0;
    #1;
    check("midreset_bypass", rdata1, 32'h77);
    step();
    drive(1'b0, 5'd0, 32'd0, 5'd7, 5'd8);
    #1;
    check("first_write_after_reset", rdata1, 32'h77);
    check("first_write_wb_valid", {31'd0, wb_valid}, 32'd1);
    check("first_write_wb_addr", {27'd0, wb_addr}, 32'd7);
    step();
    step();

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
